button_event_arbiter: RTL and testbench

- Collects short-press, long-press and held-level signals from N per-button debouncers and adds auto-repeat while a button stays held after a long press.
- Queues at most one event of each kind per button.
- Serialises all buttons onto a single valid/ready event stream using round-robin arbitration.
- Sits between the per-button debouncers and the front-panel command decoder.

---
 rtl/button_event_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//
// Purpose:
//   Gathers short-press, long-press and auto-repeat events from a bank of
//   debounced buttons. It keeps at most one pending event of each kind per
//   button and serialises them onto a single valid/ready stream. Buttons are
//   served in round-robin order.
//
//   While a button stays held after a long press, a per-button repeat timer
//   produces a REPEAT event every REPEAT_CYCLES clocks.
//
//   Events that arrive while the same (button, kind) is already pending are
//   discarded. Each discard is counted in a saturating 8-bit counter.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   short_pulse  per-button one-cycle short-press pulse
//   long_pulse   per-button one-cycle long-press pulse
//   held         per-button synchronized level (1 = pressed)
//   repeat_en    enables auto-repeat generation
//   evt_valid    output event available
//   evt_ready    consumer accepts the event
//   evt_btn      button index of the event
//   evt_kind     0 = SHORT, 1 = LONG, 2 = REPEAT
//   drop_count   saturating count of discarded events

module button_event_arbiter #(
  parameter int N_BTN         = 5,
  parameter int REPEAT_CYCLES = 25000000,
  localparam int BTN_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] short_pulse,
  input  logic [N_BTN-1:0] long_pulse,
  input  logic [N_BTN-1:0] held,
  input  logic             repeat_en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [BTN_W-1:0] evt_btn,
  output logic [1:0]       evt_kind,
  output logic [7:0]       drop_count
);

  localparam int CNT_W = $clog2(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REPEAT_CYCLES - 1);

  localparam logic [1:0] KIND_SHORT  = 2'd0;
  localparam logic [1:0] KIND_LONG   = 2'd1;
  localparam logic [1:0] KIND_REPEAT = 2'd2;

  typedef enum logic {
    RPT_IDLE  = 1'b0,
    RPT_ARMED = 1'b1
  } rpt_state_e;

  // Repeat timers
  rpt_state_e       rpt_state_q [N_BTN];
  rpt_state_e       rpt_state_d [N_BTN];
  logic [CNT_W-1:0] rpt_cnt_q   [N_BTN];
  logic [CNT_W-1:0] rpt_cnt_d   [N_BTN];
  logic [N_BTN-1:0] rpt_tick;

  // Pending flags, indexed [kind][button]
  logic [2:0][N_BTN-1:0] pend_q, pend_d;
  logic [2:0][N_BTN-1:0] set_req, clr, drop;

  // Output register and arbitration state
  logic             evt_valid_q, evt_valid_d;
  logic [BTN_W-1:0] evt_btn_q, evt_btn_d;
  logic [1:0]       evt_kind_q, evt_kind_d;
  logic [BTN_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]       drop_count_q, drop_count_d;

  logic             win_found;
  logic [BTN_W-1:0] win_btn;
  logic [1:0]       win_kind;
  logic [BTN_W-1:0] cand;
  logic             load;
  int               drop_total;

  // Modular addition over the button range, wrapping N_BTN-1 -> 0.
  function automatic logic [BTN_W-1:0] btn_add(input logic [BTN_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_BTN) s = s - N_BTN;
    return BTN_W'(s);
  endfunction

  // Repeat timer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        rpt_state_q[i] <= RPT_IDLE;
        rpt_cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        rpt_state_q[i] <= rpt_state_d[i];
        rpt_cnt_q[i]   <= rpt_cnt_d[i];
      end
    end
  end

  // Repeat timer next state.
  // When the timer is armed, dropping the button or repeat_en disarms it at
  // once. A fresh long press restarts the count from zero.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      rpt_state_d[i] = rpt_state_q[i];
      rpt_cnt_d[i]   = rpt_cnt_q[i];
      case (rpt_state_q[i])
        RPT_IDLE: begin
          if (long_pulse[i] && held[i] && repeat_en) begin
            rpt_state_d[i] = RPT_ARMED;
            rpt_cnt_d[i]   = '0;
          end
        end
        RPT_ARMED: begin
          if (!held[i] || !repeat_en) begin
            rpt_state_d[i] = RPT_IDLE;
            rpt_cnt_d[i]   = '0;
          end else if (long_pulse[i] || rpt_cnt_q[i] == CNT_MAX) begin
            rpt_cnt_d[i] = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
          end
        end
        default: begin
          rpt_state_d[i] = RPT_IDLE;
          rpt_cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Repeat tick output.
  // A tick fires only when the timer stays armed and is not restarted on
  // this edge.
  always_comb begin
    rpt_tick = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rpt_tick[i] = (rpt_state_q[i] == RPT_ARMED) && held[i] && repeat_en &&
                    !long_pulse[i] && (rpt_cnt_q[i] == CNT_MAX);
    end
  end

  // Round-robin winner search.
  // The scan starts at rr_ptr. The first button with any pending kind wins,
  // and the lowest-numbered kind is taken within that button.
  always_comb begin
    win_found = 1'b0;
    win_btn   = '0;
    win_kind  = KIND_SHORT;
    cand      = '0;
    for (int off = 0; off < N_BTN; off++) begin
      cand = btn_add(rr_ptr_q, off);
      if (!win_found &&
          (pend_q[0][cand] || pend_q[1][cand] || pend_q[2][cand])) begin
        win_found = 1'b1;
        win_btn   = cand;
        if (pend_q[0][cand])      win_kind = KIND_SHORT;
        else if (pend_q[1][cand]) win_kind = KIND_LONG;
        else                      win_kind = KIND_REPEAT;
      end
    end
  end

  // Pending flag, output register and drop counter update.
  //
  // A set and a consume of the same bit on one edge leave the bit set, and
  // nothing is lost. Only a set on a bit that stays pending is discarded.
  always_comb begin
    load       = !evt_valid_q || evt_ready;
    set_req[0] = short_pulse;
    set_req[1] = long_pulse;
    set_req[2] = rpt_tick;

    clr = '0;
    if (load && win_found) clr[win_kind][win_btn] = 1'b1;

    drop   = set_req & pend_q & ~clr;
    pend_d = (pend_q & ~clr) | set_req;

    drop_total = int'(drop_count_q) + $countones(drop);
    drop_count_d = (drop_total > 255) ? 8'hFF : 8'(drop_total);

    evt_valid_d = evt_valid_q;
    evt_btn_d   = evt_btn_q;
    evt_kind_d  = evt_kind_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      evt_valid_d = win_found;
      if (win_found) begin
        evt_btn_d  = win_btn;
        evt_kind_d = win_kind;
        rr_ptr_d   = btn_add(win_btn, 1);
      end
    end
  end

  // Output, pending and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      evt_valid_q  <= 1'b0;
      evt_btn_q    <= '0;
      evt_kind_q   <= KIND_SHORT;
      rr_ptr_q     <= '0;
      drop_count_q <= '0;
    end else begin
      pend_q       <= pend_d;
      evt_valid_q  <= evt_valid_d;
      evt_btn_q    <= evt_btn_d;
      evt_kind_q   <= evt_kind_d;
      rr_ptr_q     <= rr_ptr_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_btn    = evt_btn_q;
  assign evt_kind   = evt_kind_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter
//
// Purpose:
//   Self-checking bench for button_event_arbiter with five buttons and a
//   short repeat period.
//
//   Every accepted event is popped from an expected-event queue and compared
//   against the head entry. Table vectors cover round-robin ordering, and
//   hand-written sequences cover latency, auto-repeat, backpressure,
//   overflow and asynchronous reset.

module tb_button_event_arbiter;

  localparam int N_BTN         = 5;
  localparam int REPEAT_CYCLES = 10;

  logic             clk;
  logic             rst_n;
  logic [N_BTN-1:0] short_pulse;
  logic [N_BTN-1:0] long_pulse;
  logic [N_BTN-1:0] held;
  logic             repeat_en;
  logic             evt_valid;
  logic             evt_ready;
  logic [2:0]       evt_btn;
  logic [1:0]       evt_kind;
  logic [7:0]       drop_count;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int btn;
    int kind;
  } evt_t;

  evt_t exp_q[$];
  evt_t mon_e;

  // One table row is a single-cycle burst of pulses.
  // seq lists the expected accepted events, first event in the top nibble.
  // Each nibble is {is_long, btn[2:0]}.
  typedef struct {
    logic [4:0]  s;
    logic [4:0]  l;
    int          n;
    logic [39:0] seq;
  } vec_t;

  vec_t tbl [7] = '{
    '{5'b10101, 5'b00000,  3, 40'h0240000000},
    '{5'b10001, 5'b00000,  2, 40'h0400000000},
    '{5'b00100, 5'b00000,  1, 40'h2000000000},
    '{5'b10001, 5'b00000,  2, 40'h4000000000},
    '{5'b00011, 5'b00010,  3, 40'h1090000000},
    '{5'b11111, 5'b11111, 10, 40'h23401ABC89},
    '{5'b00000, 5'b01000,  1, 40'hB000000000}
  };

  button_event_arbiter #(
    .N_BTN(N_BTN),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .short_pulse(short_pulse),
    .long_pulse(long_pulse),
    .held(held),
    .repeat_en(repeat_en),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_btn(evt_btn),
    .evt_kind(evt_kind),
    .drop_count(drop_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Scoreboard.
  // Inputs only change just after a rising edge, so the falling edge shows
  // the values that the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_event: got btn=%0d kind=%0d, required no event",
                 evt_btn, evt_kind);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(evt_btn) != mon_e.btn || int'(evt_kind) != mon_e.kind) begin
          mismatched++;
          $display("[TB] FAIL event_order: got btn=%0d kind=%0d, required btn=%0d kind=%0d",
                   evt_btn, evt_kind, mon_e.btn, mon_e.kind);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] s, input logic [4:0] l,
                               input logic [4:0] h, input logic rdy);
    short_pulse = s;
    long_pulse  = l;
    held        = h;
    evt_ready   = rdy;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic push_evt(input int b, input int k);
    evt_t e;
    e.btn  = b;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Wait a bounded number of cycles for all expected events to be accepted.
  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain_timeout: got %0d events outstanding, required 0",
               exp_q.size());
      exp_q.delete();
    end
    repeat (3) step();
  endtask

  initial begin
    logic [39:0] seq_v;
    logic [3:0]  nib;

    clk         = 1'b0;
    rst_n       = 1'b0;
    repeat_en   = 1'b1;
    short_pulse = '0;
    long_pulse  = '0;
    held        = '0;
    evt_ready   = 1'b1;

    // Reset state
    do_reset();
    checkOutput("reset_valid", evt_valid, 0);
    checkOutput("reset_btn", evt_btn, 0);
    checkOutput("reset_kind", evt_kind, 0);
    checkOutput("reset_drop", drop_count, 0);

    // Single SHORT: valid for exactly one cycle, two edges after the pulse
    push_evt(2, 0);
    applyStimulus(5'b00100, 5'b0, 5'b0, 1'b1);
    step();
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
    checkOutput("short_early", evt_valid, 0);
    step();
    checkOutput("short_valid", evt_valid, 1);
    checkOutput("short_btn", evt_btn, 2);
    checkOutput("short_kind", evt_kind, 0);
    step();
    checkOutput("short_once", evt_valid, 0);
    wait_drain(5);

    // Round-robin table
    do_reset();
    for (int v = 0; v < 7; v++) begin
      seq_v = tbl[v].seq;
      for (int j = 0; j < tbl[v].n; j++) begin
        nib = seq_v[39-4*j -: 4];
        push_evt(int'(nib[2:0]), int'(nib[3]));
      end
      applyStimulus(tbl[v].s, tbl[v].l, 5'b0, 1'b1);
      step();
      applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
      wait_drain(30);
      checkOutput($sformatf("rr_drop_v%0d", v), drop_count, 0);
    end

    // Auto-repeat: LONG, then ticks 10 and 20 cycles later; release at 25
    do_reset();
    push_evt(1, 1);
    push_evt(1, 2);
    push_evt(1, 2);
    applyStimulus(5'b0, 5'b00010, 5'b00010, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1)  applyStimulus(5'b0, 5'b0, 5'b00010, 1'b1);
      if (k == 25) applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
      checkOutput($sformatf("rpt_valid_c%0d", k), evt_valid,
                  (k == 2 || k == 12 || k == 22) ? 1 : 0);
    end
    wait_drain(5);

    // Backpressure: output holds for 20 cycles, then three events drain
    do_reset();
    push_evt(0, 0);
    push_evt(1, 0);
    push_evt(3, 0);
    applyStimulus(5'b01011, 5'b0, 5'b0, 1'b0);
    step();
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b0);
    step();
    for (int k = 0; k < 20; k++) begin
      checkOutput("bp_hold", int'({evt_valid, evt_btn, evt_kind}), 32);
      step();
    end
    checkOutput("bp_drop", drop_count, 0);
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
    step();
    checkOutput("bp_drain1", int'({evt_valid, evt_btn, evt_kind}), 36);
    step();
    checkOutput("bp_drain2", int'({evt_valid, evt_btn, evt_kind}), 44);
    step();
    checkOutput("bp_drained", evt_valid, 0);
    wait_drain(5);

    // Several discards in one cycle, then drain in round-robin order
    do_reset();
    applyStimulus(5'b11111, 5'b0, 5'b0, 1'b0);
    step();
    applyStimulus(5'b11111, 5'b0, 5'b0, 1'b0);
    step();
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b0);
    step();
    checkOutput("multi_drop", drop_count, 4);
    push_evt(0, 0);
    push_evt(1, 0);
    push_evt(2, 0);
    push_evt(3, 0);
    push_evt(4, 0);
    push_evt(0, 0);
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
    wait_drain(20);

    // Overflow and saturation on one button
    do_reset();
    repeat (4) begin
      applyStimulus(5'b01000, 5'b0, 5'b0, 1'b0);
      step();
    end
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b0);
    step();
    checkOutput("ovf_drop2", drop_count, 2);
    checkOutput("ovf_held_evt", int'({evt_valid, evt_btn, evt_kind}), 44);
    repeat (100) begin
      applyStimulus(5'b01000, 5'b0, 5'b0, 1'b0);
      step();
    end
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b0);
    step();
    checkOutput("ovf_drop102", drop_count, 102);
    repeat (200) begin
      applyStimulus(5'b01000, 5'b0, 5'b0, 1'b0);
      step();
    end
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b0);
    step();
    checkOutput("ovf_sat", drop_count, 255);
    push_evt(3, 0);
    push_evt(3, 0);
    applyStimulus(5'b0, 5'b0, 5'b0, 1'b1);
    wait_drain(10);
    checkOutput("ovf_sat_kept", drop_count, 255);

    // Async reset mid-transfer with repeat armed
    do_reset();
    applyStimulus(5'b0, 5'b00010, 5'b00010, 1'b0);
    step();
    applyStimulus(5'b0, 5'b0, 5'b00010, 1'b0);
    step();
    checkOutput("arst_pre_valid", evt_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid_drop", evt_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(5'b0, 5'b0, 5'b00010, 1'b1);
    for (int k = 0; k < 30; k++) begin
      step();
      checkOutput("arst_no_repeat", evt_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
